// File: rtl/rsa_me_sched.sv
// LSB-first modular exponentiation scheduler sharing one Montgomery multiplier
// between the multiply (S*T) and square (T*T) steps.
module rsa_me_sched #(
  parameter int WIDTH = 256,
  parameter int EBITS = 256,
  localparam int JW = $clog2(EBITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [EBITS-1:0] e,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             pre_start,
  input  logic             pre_done,
  input  logic [WIDTH-1:0] pre_val,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_res,
  output logic [2:0]       dbg_state,
  output logic [JW-1:0]    dbg_j,
  output logic [WIDTH-1:0] dbg_n
);

  // Handshakes: pre_start/mm_start are single-cycle launch pulses; the matching
  // pre_done/mm_done is accepted only in the waiting state, and mm_done only
  // after the launch cycle. ready is a single-cycle pulse in DONE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SCAN = 3'd2,
    MUL  = 3'd3,
    SQR  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [JW-1:0]    j;
  logic [JW-1:0]    msb;
  logic [WIDTH-1:0] s_reg, t_reg, n_reg;
  logic [EBITS-1:0] e_reg;
  logic             issued;
  logic             mm_ack;

  // issued marks that this MUL/SQR visit has already launched its MA op.
  assign mm_ack = issued & mm_done;

  always_comb begin
    msb = '0;
    for (int i = 0; i < EBITS; i++) begin
      if (e_reg[i]) msb = JW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      j      <= '0;
      s_reg  <= '0;
      t_reg  <= '0;
      n_reg  <= '0;
      e_reg  <= '0;
      issued <= 1'b0;
    end else begin
      state  <= state_next;
      issued <= ((state == MUL) || (state == SQR)) && (state_next == state);
      unique case (state)
        IDLE: begin
          if (start) begin
            s_reg <= WIDTH'(1);
            n_reg <= N;
            e_reg <= e;
            j     <= '0;
          end
        end
        PRE: begin
          if (pre_done) t_reg <= pre_val;
        end
        MUL: begin
          if (mm_ack) s_reg <= mm_res;
        end
        SQR: begin
          if (mm_ack) begin
            t_reg <= mm_res;
            j     <= j + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    pre_start  = 1'b0;
    mm_start   = 1'b0;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (e == '0) ? DONE : PRE;
          pre_start  = (e != '0);
        end
      end
      PRE: begin
        if (pre_done) state_next = SCAN;
      end
      SCAN: begin
        state_next = e_reg[j] ? MUL : SQR;
      end
      MUL: begin
        mm_start = ~issued;
        // The last multiply at the top bit ends the run; no trailing square.
        if (mm_ack) state_next = (j == msb) ? DONE : SQR;
      end
      SQR: begin
        mm_start = ~issued;
        if (mm_ack) state_next = SCAN;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign result    = s_reg;
  assign mm_a      = (state == MUL) ? s_reg : t_reg;
  assign mm_b      = t_reg;
  assign dbg_state = state;
  assign dbg_j     = j;
  assign dbg_n     = n_reg;

endmodule

// File: tb/tb_rsa_me_sched.sv
// Bench for rsa_me_sched: behavioural pre-processing and Montgomery models,
// plain square-and-multiply reference with an expected operand schedule.
module tb_rsa_me_sched;
  localparam int W      = 256;
  localparam int EB     = 256;
  localparam int JW     = 8;
  localparam int MA_LAT = 133;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  n_in;
  logic [EB-1:0] e_in;
  logic          busy, ready, pre_start, pre_done, mm_start, mm_done;
  logic [W-1:0]  result, pre_val, mm_a, mm_b, mm_res, dbg_n;
  logic [2:0]    dbg_state;
  logic [JW-1:0] dbg_j;

  int tests = 0;
  int fails = 0;

  rsa_me_sched #(.WIDTH(W), .EBITS(EB)) dut (
    .clk(clk), .rst(rst), .start(start), .N(n_in), .e(e_in),
    .busy(busy), .ready(ready), .result(result),
    .pre_start(pre_start), .pre_done(pre_done), .pre_val(pre_val),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_res(mm_res),
    .dbg_state(dbg_state), .dbg_j(dbg_j), .dbg_n(dbg_n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- arithmetic helpers ----------------
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p, r;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = p % {{W{1'b0}}, n};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] n);
    logic [2*W-1:0] p, r;
    p = {x, {W{1'b0}}};
    r = p % {{W{1'b0}}, n};
    return r[W-1:0];
  endfunction

  // Bit-serial a*b*2^-W mod n, used only as the multiplier model.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] n);
    logic [W+1:0] x;
    x = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) x = x + {2'b00, b};
      if (x[0]) x = x + {2'b00, n};
      x = x >> 1;
    end
    if (x >= {2'b00, n}) x = x - {2'b00, n};
    return x[W-1:0];
  endfunction

  // ---------------- environment models ----------------
  logic [W-1:0]   cur_n = '0, cur_m = '0;
  logic [2*W-1:0] exp_ops[$];
  int             op_base = 0;
  int             mm_cnt = 0, pre_cnt = 0, ready_cnt = 0, overlap_cnt = 0;
  int             pre_timer = 0, ma_timer = 0;
  logic [W-1:0]   ma_a, ma_b, ma_res = '0;
  logic           ma_done = 1'b0, stray_done;

  assign mm_done = ma_done | stray_done;
  assign mm_res  = stray_done ? {W{1'b1}} : ma_res;

  always @(posedge clk) begin
    pre_done <= 1'b0;
    if (pre_start) begin
      pre_timer <= $urandom_range(2, 8);
    end else if (pre_timer > 0) begin
      if (pre_timer == 1) begin
        pre_done <= 1'b1;
        pre_val  <= to_mont(cur_m % cur_n, cur_n);
      end
      pre_timer <= pre_timer - 1;
    end
  end

  always @(posedge clk) begin
    ma_done <= 1'b0;
    if (mm_start) begin
      if (ma_timer > 0) overlap_cnt <= overlap_cnt + 1;
      ma_a     <= mm_a;
      ma_b     <= mm_b;
      ma_timer <= MA_LAT;
    end else if (ma_timer > 0) begin
      if (ma_timer == 1) begin
        ma_done <= 1'b1;
        ma_res  <= mont(ma_a, ma_b, cur_n);
      end
      ma_timer <= ma_timer - 1;
    end
  end

  // Operand scoreboard: every launched op must match the next scheduled one.
  always @(negedge clk) begin
    if (mm_start) begin
      int idx;
      idx = mm_cnt - op_base;
      if (idx < exp_ops.size()) begin
        check_val("mm_a", mm_a, exp_ops[idx][2*W-1:W]);
        check_val("mm_b", mm_b, exp_ops[idx][W-1:0]);
      end
      mm_cnt <= mm_cnt + 1;
    end
    if (pre_start) pre_cnt <= pre_cnt + 1;
    if (ready) ready_cnt <= ready_cnt + 1;
  end

  // Reference: plain right-to-left square-and-multiply, S kept plain, T in Montgomery form.
  task automatic build_model(input logic [W-1:0] m, input logic [W-1:0] n, input logic [EB-1:0] ee,
                             output logic [W-1:0] res, output int nops, output int top);
    logic [W-1:0] s, t;
    exp_ops.delete();
    s = 1;
    t = m % n;
    top = 0;
    nops = 0;
    for (int i = 0; i < EB; i++) if (ee[i]) top = i;
    if (ee != '0) begin
      for (int i = 0; i <= top; i++) begin
        if (ee[i]) begin
          exp_ops.push_back({s, to_mont(t, n)});
          s = mulmod(s, t, n);
          nops++;
        end
        if (i < top) begin
          exp_ops.push_back({to_mont(t, n), to_mont(t, n)});
          t = mulmod(t, t, n);
          nops++;
        end
      end
    end
    res = s;
  endtask

  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] n, input logic [EB-1:0] ee,
                        output logic [W-1:0] res, output int nops, output int top);
    cur_m = m;
    cur_n = n;
    build_model(m, n, ee, res, nops, top);
    op_base = mm_cnt;
    n_in  = n;
    e_in  = ee;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_exp(input string tag, input logic [W-1:0] m, input logic [W-1:0] n,
                         input logic [EB-1:0] ee, input bit poke, output int lat);
    logic [W-1:0] res;
    int nops, top, mm0, pre0, rdy0, budget;
    bit got, poked;
    mm0 = mm_cnt; pre0 = pre_cnt; rdy0 = ready_cnt;
    got = 0; poked = 0; lat = -1;
    launch(m, n, ee, res, nops, top);
    budget = nops * (MA_LAT + 3) + 40;
    for (int c = 0; c < budget; c++) begin
      if (ready) begin
        got = 1;
        lat = c;
        break;
      end
      if (poke && !poked && (mm_cnt - mm0 == 2)) begin
        n_in  = ~n;
        e_in  = ee ^ EB'(7);
        start = 1'b1;
        poked = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_in  = n;
      e_in  = ee;
    end
    check_val({tag, "_ready_seen"}, W'(got), W'(1));
    check_val({tag, "_result"}, result, res);
    @(posedge clk); #1;
    check_val({tag, "_busy_after"}, W'(busy), W'(0));
    check_val({tag, "_ready_pulses"}, W'(ready_cnt - rdy0), W'(1));
    check_val({tag, "_mm_starts"}, W'(mm_cnt - mm0), W'(nops));
    check_val({tag, "_pre_starts"}, W'(pre_cnt - pre0), W'(ee != '0));
    check_val({tag, "_latched_n"}, dbg_n, n);
    check_val({tag, "_final_j"}, W'(dbg_j), W'(top));
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] n_r, m_r, p25519, res_d, keep;
    logic [EB-1:0] e_big;
    int lat, nops, top, mm0, bound;

    rst = 1'b1; start = 1'b0; n_in = '0; e_in = '0; stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", W'(busy), W'(0));
    check_val("rst_ready", W'(ready), W'(0));
    check_val("rst_result", result, W'(0));
    check_val("rst_pre_start", W'(pre_start), W'(0));
    check_val("rst_mm_start", W'(mm_start), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_exp("e13", W'(4), W'(497), EB'(13), 1'b0, lat);
    check_val("e13_const", result, W'(445));

    run_exp("e1", W'(4), W'(497), EB'(1), 1'b0, lat);
    check_val("e1_const", result, W'(4));

    n_r = rand_w(); n_r[0] = 1'b1; n_r[W-1] = 1'b1;
    run_exp("e0", W'(9), n_r, '0, 1'b0, lat);
    check_val("e0_const", result, W'(1));
    check_val("e0_ready_lat", W'(lat), W'(0));

    // Stray multiplier completion while idle must not disturb anything.
    keep = result;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(posedge clk); #1;
    check_val("stray_busy", W'(busy), W'(0));
    check_val("stray_result", result, keep);

    run_exp("poke", W'(4), W'(497), EB'(13), 1'b1, lat);
    check_val("poke_const", result, W'(445));

    for (int r = 0; r < 5; r++) begin
      n_r = rand_w(); n_r[0] = 1'b1; n_r[W-1] = 1'b1;
      m_r = rand_w() % n_r;
      run_exp($sformatf("rnd%0d", r), m_r, n_r, EB'($urandom_range(0, 4095)), 1'b0, lat);
    end

    p25519 = '0; p25519[255] = 1'b1; p25519 = p25519 - W'(19);
    e_big = '0; e_big[255] = 1'b1;
    m_r = rand_w() % p25519;
    run_exp("e2_255", m_r, p25519, e_big, 1'b0, lat);

    // Abort mid-multiply with a one-cycle reset.
    mm0 = mm_cnt;
    launch(W'(4), W'(497), EB'(13), res_d, nops, top);
    bound = 0;
    while ((mm_cnt == mm0) && (bound < 100)) begin
      @(posedge clk); #1;
      bound++;
    end
    check_val("abort_mul_seen", W'(mm_cnt - mm0), W'(1));
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", W'(busy), W'(0));
    check_val("abort_result", result, W'(0));
    bound = 0;
    while ((ma_timer > 0) && (bound < 200)) begin
      @(posedge clk); #1;
      bound++;
    end
    @(posedge clk); #1;
    check_val("late_done_busy", W'(busy), W'(0));
    check_val("late_done_result", result, W'(0));
    run_exp("after_abort", W'(4), W'(497), EB'(13), 1'b0, lat);
    check_val("after_abort_const", result, W'(445));

    check_val("no_overlap", W'(overlap_cnt), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
